// File: rtl/seq_divider.sv
// Sequential signed restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Results appear WIDTH+2 clocks after a Run rising edge.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] S,
    input  logic             LoadHi,
    input  logic             LoadLo,
    input  logic             LoadD,
    input  logic             Run,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             DivZero,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] L_MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_MAXNEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t           r_state, w_next;
    logic             r_run_d;
    logic [W2-1:0]    r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_nlo;
    logic [WIDTH-1:0] r_dmag;
    logic             r_sq, r_sr, r_dz_p, r_ovf_p;
    logic [CW-1:0]    r_cnt;

    logic             w_idle_like, w_start, w_ge, w_ovf_fix, w_last;
    logic [W2-1:0]    w_nmag;
    logic [WIDTH-1:0] w_dmag, w_q_neg, w_r_neg;
    logic [WIDTH:0]   w_shift, w_diff;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start     = Run && !r_run_d && w_idle_like;
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    assign w_nmag  = r_dividend[W2-1] ? -r_dividend : r_dividend;
    assign w_dmag  = r_divisor[WIDTH-1] ? -r_divisor : r_divisor;
    // Quotient bits shift into r_nlo as the dividend low half shifts out.
    assign w_shift = {r_p[WIDTH-1:0], r_nlo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dmag});
    assign w_diff  = w_shift - {1'b0, r_dmag};
    assign w_q_neg = -r_nlo;
    assign w_r_neg = -r_p[WIDTH-1:0];
    assign w_ovf_fix = r_ovf_p || (!r_sq && (r_nlo > L_MAXPOS)) || (r_sq && (r_nlo > L_MAXNEG));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_PREP;
            S_PREP: begin
                Busy   = 1'b1;
                w_next = S_ITER;
            end
            S_ITER: begin
                Busy = 1'b1;
                if (w_last) w_next = S_FIX;
            end
            S_FIX: begin
                Busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                Done = 1'b1;
                if (w_start) w_next = S_PREP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_run_d    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_p        <= '0;
            r_nlo      <= '0;
            r_dmag     <= '0;
            r_sq       <= 1'b0;
            r_sr       <= 1'b0;
            r_dz_p     <= 1'b0;
            r_ovf_p    <= 1'b0;
            r_cnt      <= '0;
            Qval       <= '0;
            Rval       <= '0;
            DivZero    <= 1'b0;
            Ovf        <= 1'b0;
        end else begin
            r_run_d <= Run;
            // A start edge keeps the operands it sampled; coincident loads are dropped.
            if (w_idle_like && !w_start) begin
                if (LoadHi) r_dividend[W2-1:WIDTH] <= S;
                if (LoadLo) r_dividend[WIDTH-1:0]  <= S;
                if (LoadD)  r_divisor              <= S;
            end
            case (r_state)
                S_PREP: begin
                    r_p     <= {1'b0, w_nmag[W2-1:WIDTH]};
                    r_nlo   <= w_nmag[WIDTH-1:0];
                    r_dmag  <= w_dmag;
                    r_sq    <= r_dividend[W2-1] ^ r_divisor[WIDTH-1];
                    r_sr    <= r_dividend[W2-1];
                    r_dz_p  <= (r_divisor == '0);
                    r_ovf_p <= (w_nmag[W2-1:WIDTH] >= w_dmag);
                    r_cnt   <= '0;
                end
                S_ITER: begin
                    r_p   <= w_ge ? w_diff : w_shift;
                    r_nlo <= {r_nlo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    DivZero <= r_dz_p;
                    Ovf     <= w_ovf_fix;
                    if (r_dz_p || w_ovf_fix) begin
                        Qval <= '0;
                        Rval <= '0;
                    end else begin
                        Qval <= r_sq ? w_q_neg : r_nlo;
                        Rval <= r_sr ? w_r_neg : r_p[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on each rising Done.
module tb_seq_divider;

    typedef struct {
        int       id;
        logic [7:0] q;
        logic [7:0] r;
        logic     dz;
        logic     ovf;
        bit       chk_ovf;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] S = '0;
    logic       LoadHi = 1'b0, LoadLo = 1'b0, LoadD = 1'b0, Run = 1'b0;
    logic [7:0] Qval, Rval;
    logic       DivZero, Ovf, Busy, Done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic mon_prev_done = 1'b0;

    seq_divider #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .S(S),
        .LoadHi(LoadHi), .LoadLo(LoadLo), .LoadD(LoadD), .Run(Run),
        .Qval(Qval), .Rval(Rval), .DivZero(DivZero), .Ovf(Ovf),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset && Done && !mon_prev_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Done with empty scoreboard at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk($sformatf("op%0d_Qval", e.id), 32'(Qval), 32'(e.q));
                chk($sformatf("op%0d_Rval", e.id), 32'(Rval), 32'(e.r));
                chk($sformatf("op%0d_DivZero", e.id), 32'(DivZero), 32'(e.dz));
                if (e.chk_ovf) chk($sformatf("op%0d_Ovf", e.id), 32'(Ovf), 32'(e.ovf));
            end
        end
        mon_prev_done = Done;
    end

    task automatic load_ops(input logic [15:0] n, input logic [7:0] d);
        @(negedge Clk); S = n[15:8]; LoadHi = 1'b1;
        @(negedge Clk); LoadHi = 1'b0; S = n[7:0]; LoadLo = 1'b1;
        @(negedge Clk); LoadLo = 1'b0; S = d; LoadD = 1'b1;
        @(negedge Clk); LoadD = 1'b0;
    endtask

    // mode: 0 normal, 1 hold Run high, 2 toggle LoadD while busy, 3 load at start edge
    task automatic run_op(input logic [15:0] n, input logic [7:0] d, input exp_t e, input int mode);
        int first;
        load_ops(n, d);
        @(negedge Clk);
        Run = 1'b1;
        if (mode == 3) begin S = 8'h01; LoadD = 1'b1; end
        sb.push_back(e);
        first = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk); #1;
            if (k == 0) begin
                chk($sformatf("op%0d_busy_after_start", e.id), 32'(Busy), 32'd1);
                LoadD = 1'b0;
                if (mode != 1) Run = 1'b0;
                if (mode == 2) begin S = 8'h02; LoadD = 1'b1; end
            end
            if (k == 4 && mode == 2) LoadD = 1'b0;
            if (Done) begin first = k; break; end
        end
        chk($sformatf("op%0d_latency", e.id), 32'(first), 32'd10);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_seen;
        #12;
        chk("reset_Qval", 32'(Qval), 32'h0);
        chk("reset_Rval", 32'(Rval), 32'h0);
        chk("reset_DivZero", 32'(DivZero), 32'h0);
        chk("reset_Ovf", 32'(Ovf), 32'h0);
        chk("reset_Busy", 32'(Busy), 32'h0);
        chk("reset_Done", 32'(Done), 32'h0);
        @(negedge Clk); Reset = 1'b1;

        run_op(16'h0019, 8'h07, '{1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'hFE63, 8'h07, '{2, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'h000C, 8'h03, '{3, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'hFFF3, 8'h04, '{4, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'h000D, 8'hFC, '{5, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b1}, 0);

        // Results must hold while new operands load in DONE.
        load_ops(16'h1234, 8'h56);
        chk("hold_Qval_after_load", 32'(Qval), 32'hFD);
        chk("hold_Rval_after_load", 32'(Rval), 32'h01);

        run_op(16'h0019, 8'h00, '{6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}, 0);
        run_op(16'h0080, 8'h01, '{7, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}, 0);
        run_op(16'hFF80, 8'h01, '{8, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'h4000, 8'h01, '{9, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}, 0);

        run_op(16'h0019, 8'h07, '{10, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1}, 1);
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (Busy || !Done) busy_seen++;
        end
        chk("run_held_no_retrigger", 32'(busy_seen), 32'd0);
        @(negedge Clk); Run = 1'b0;

        run_op(16'h0019, 8'h07, '{11, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1}, 2);
        run_op(16'h000C, 8'h03, '{12, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1}, 3);

        load_ops(16'h0064, 8'h07);
        @(negedge Clk); Run = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(posedge Clk); #1;
            if (k == 0) Run = 1'b0;
        end
        chk("midop_busy_before_reset", 32'(Busy), 32'd1);
        Reset = 1'b0;
        #1;
        chk("midop_reset_Busy", 32'(Busy), 32'h0);
        chk("midop_reset_Done", 32'(Done), 32'h0);
        chk("midop_reset_Qval", 32'(Qval), 32'h0);
        chk("midop_reset_Rval", 32'(Rval), 32'h0);
        @(negedge Clk); Reset = 1'b1;

        run_op(16'hFFF3, 8'h04, '{13, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b1}, 0);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed divider; the inverse of the lab shift-add multiplier.
- Takes a 2*WIDTH-bit two's-complement dividend and a WIDTH-bit divisor, loaded from the switch bus S.
- Produces a truncating quotient and remainder after a fixed WIDTH+2 clock latency. One restoring-division step is performed per clock.
- Sits beside the multiplier in the lab top level and shares its switch/button front end.

Parameters:
WIDTH, 8, operand width; dividend is 2*WIDTH bits; quotient and remainder are WIDTH bits.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
S  input  WIDTH  switch data bus used by the load strobes.
LoadHi  input  1  level; while high and not Busy, dividend[2W-1:W] <= S each clock.
LoadLo  input  1  level; while high and not Busy, dividend[W-1:0] <= S each clock.
LoadD  input  1  level; while high and not Busy, divisor <= S each clock.
Run  input  1  start request; synchronous, rising-edge detected internally.
Qval  output  WIDTH  registered signed quotient.
Rval  output  WIDTH  registered signed remainder; sign follows the dividend.
DivZero  output  1  set when the last operation had divisor == 0.
Ovf  output  1  set when the true quotient does not fit signed WIDTH.
Busy  output  1  high while an operation is in progress.
Done  output  1  high from completion until the next start.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, operand registers 0, Qval=0, Rval=0, DivZero=0, Ovf=0, Busy=0, Done=0, Run edge detector cleared.
- Start condition: Run=1 sampled at an edge E0 while Run was 0 at the previous edge, with state IDLE or DONE.
  - Run held high never retriggers; a start requires Run to go low and then high again.
- States: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE.
  - DONE -> PREP on a new start; DONE otherwise holds, with Run level irrelevant.
- E0: state goes to PREP; Busy=1, Done=0.
- Edge in PREP:
  - Take magnitudes: |N| is 2W bits unsigned (|0x8000| = 0x8000 for W=8); |D| is W bits.
  - Record sign flags sq = sN^sD and sr = sN.
  - DivZero_pending = (D==0); ovf_pending = (|N| high half >= |D|).
- Each ITER edge, restoring step on the W+1-bit partial remainder P:
  - {P, Nlo} shifted left by 1.
  - If P >= |D|: P -= |D| and the quotient bit = 1; else the quotient bit = 0.
  - An iteration counter counts WIDTH steps and then moves to FIX.
- FIX edge:
  - Apply signs: Q = sq ? -Qmag : Qmag; R = sr ? -Rmag : Rmag.
  - Ovf is also set if Qmag > 2^(W-1)-1 with sq=0, or Qmag > 2^(W-1) with sq=1.
  - If DivZero or Ovf: Qval=0, Rval=0.
  - Otherwise Qval/Rval = Q/R.
  - Busy=0, Done=1, state DONE.
- Latency: Done and results are valid after edge E0+WIDTH+2, i.e. E10 for W=8. Error cases use the same latency.
- Qval, Rval, DivZero and Ovf change only at a FIX edge or at reset; they hold through later loads.
- While Busy=1, LoadHi, LoadLo, LoadD and Run are ignored.
- Loads may change operands in DONE without affecting the displayed results.
- Simultaneous load and start at E0: the start samples the operand values held before E0; the load is dropped.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is exposed.
- Remainder identity for non-error cases: N == Q*D + R, with |R| < |D| and R zero or the same sign as N.

Test Plan:
- Basic: load N=0x0019 (25), D=0x07, pulse Run -> Busy for 10 clocks; at E10 Done=1, Qval=0x03, Rval=0x04, DivZero=0, Ovf=0.
- Inverse of multiplier: N=0xFE63 (-413), D=0x07 -> Qval=0xC5 (-59), Rval=0x00. Then N=0x000C, D=0x03 -> Qval=0x04, Rval=0x00.
- Signed truncation: N=0xFFF3 (-13), D=0x04 -> Qval=0xFD, Rval=0xFF. Also N=0x000D, D=0xFC -> Qval=0xFD, Rval=0x01.
- Errors:
  - D=0x00 -> at E10 DivZero=1, Qval=0x00, Rval=0x00.
  - N=0x0080, D=0x01 -> Ovf=1.
  - N=0xFF80, D=0x01 -> Qval=0x80, Ovf=0.
  - N=0x4000, D=0x01 -> Ovf=1.
- Run handling: hold Run high for 30 clocks after Done -> exactly one operation. Toggle LoadD with S=0x02 while Busy -> result uses the original divisor.
- Reset mid-op: drive Reset=0 between E4 and E5 -> Busy, Done, Qval and Rval are 0 before the next edge. After release, a new Run computes correctly.
